// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and address helpers for the multi-port register file
package regfile_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREG_DEFAULT = 32;
  localparam int REG_ZERO = 0;
  function automatic int reg_aw(input int nreg);
    return $clog2(nreg);
  endfunction
  // true for a writable/readable architectural register (not x0, below NREG)
  function automatic logic reg_ok(input int addr, input int nreg);
    return addr != REG_ZERO && addr < nreg;
  endfunction
endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: read, write and scoreboard buses of the multi-port register file
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int AW = reg_aw(NREG)
);
  logic [NRD*AW-1:0] rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0] rd_busy;
  logic [NWR-1:0] wr_en;
  logic [NWR*AW-1:0] wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic sb_set_en;
  logic [AW-1:0] sb_set_addr;
  logic [NREG-1:0] busy_vec;
  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    input rd_data, rd_busy, busy_vec
  );
  modport slave (
    input rd_addr, wr_en, wr_addr, wr_data, sb_set_en, sb_set_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface

// File: rtl/regfile_rd_port.sv
// regfile_rd_port: one combinational read port with x0/range mask, write bypass and busy lookup
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int AW = reg_aw(NREG),
  parameter int NWR = 1,
  parameter int BYPASS = 1
) (
  input logic [AW-1:0] addr,
  input logic [XLEN-1:0] regs [NREG],
  input logic [NWR-1:0] wr_en,
  input logic [NWR*AW-1:0] wr_addr,
  input logic [NWR*XLEN-1:0] wr_data,
  input logic [NREG-1:0] busy_vec,
  output logic [XLEN-1:0] data,
  output logic busy
);
  logic hit, valid;
  logic [XLEN-1:0] byp;
  always_comb begin
    hit = 1'b0;
    byp = '0;
    // later ports overwrite earlier matches, so the highest-index writer wins
    for (int w = 0; w < NWR; w++)
      if (wr_en[w] && wr_addr[w*AW +: AW] == addr) begin
        hit = 1'b1;
        byp = wr_data[w*XLEN +: XLEN];
      end
    valid = reg_ok(int'(addr), NREG);
    data = !valid ? '0 : (BYPASS != 0 && hit) ? byp : regs[addr];
    busy = valid && busy_vec[addr] && !(BYPASS != 0 && hit);
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with hardwired x0 and busy scoreboard
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int NREG = NREG_DEFAULT,
  parameter int AW = reg_aw(NREG),
  parameter int NRD = 2,
  parameter int NWR = 1,
  parameter int BYPASS = 1
) (
  input logic clk,
  input logic reset,
  regfile_mp_if.slave bus
);
  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
      busy_q <= '0;
    end else begin
      for (int w = 0; w < NWR; w++)
        if (bus.wr_en[w] && reg_ok(int'(bus.wr_addr[w*AW +: AW]), NREG)) begin
          regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
          busy_q[bus.wr_addr[w*AW +: AW]] <= 1'b0;
        end
      // issued after the clears so a new producer keeps its register busy
      if (bus.sb_set_en && reg_ok(int'(bus.sb_set_addr), NREG))
        busy_q[bus.sb_set_addr] <= 1'b1;
    end
  assign bus.busy_vec = busy_q;
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    regfile_rd_port #(
      .XLEN(XLEN), .NREG(NREG), .AW(AW), .NWR(NWR), .BYPASS(BYPASS)
    ) u_rd (
      .addr(bus.rd_addr[i*AW +: AW]),
      .regs(regs),
      .wr_en(bus.wr_en),
      .wr_addr(bus.wr_addr),
      .wr_data(bus.wr_data),
      .busy_vec(busy_q),
      .data(bus.rd_data[i*XLEN +: XLEN]),
      .busy(bus.rd_busy[i])
    );
  end
endmodule
